// File: rtl/twiddle_type_seq.sv
// Per-butterfly twiddle exponent / trivial-twiddle TYPESEL sequencer for one radix-2 DIT stage.
// Optional conjugate (IFFT) exponents enabled by defining TWSEQ_INVERSE_EN (adds i_inv).
module twiddle_type_seq #(
    parameter int unsigned LOG2N = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_stage,
    input  logic             i_ready,
`ifdef TWSEQ_INVERSE_EN
    input  logic             i_inv,
`endif
    output logic [LOG2N-2:0] o_k,
    output logic [LOG2N-1:0] o_tw_exp,
    output logic             o_bypass,
    output logic [2:0]       o_typesel,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned KW        = LOG2N - 1;
    localparam int unsigned EW        = LOG2N;
    localparam int unsigned MAX_STAGE = LOG2N - 1;
    localparam logic [KW-1:0] LAST_K  = {KW{1'b1}};

    // Quarter-turn exponents: W^0 = 1, W^(N/4) = -j, W^(N/2) = -1, W^(3N/4) = +j
    localparam logic [EW-1:0] E_Q1 = EW'(1) << (LOG2N - 2);
    localparam logic [EW-1:0] E_Q2 = EW'(2) << (LOG2N - 2);
    localparam logic [EW-1:0] E_Q3 = EW'(3) << (LOG2N - 2);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_t;

    state_t          r_state;
    logic [2:0]      r_stage;
    logic            r_inv;
    logic [KW-1:0]   r_k;
    logic [EW-1:0]   r_tw_exp;
    logic            r_bypass;
    logic [2:0]      r_typesel;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic [2:0]      w_stage_cl;
    logic            w_inv_in;
    logic [KW-1:0]   w_k_next;
    logic [EW-1:0]   w_exp_next;
    logic [3:0]      w_cls_next;
    logic [EW-1:0]   w_exp_first;
    logic [3:0]      w_cls_first;

    // e = (k mod 2^s) * 2^(KW-s); conjugate is the two's complement modulo 2^EW
    function automatic logic [EW-1:0] f_exp(input logic [KW-1:0] k, input logic [2:0] s,
                                            input logic inv);
        logic [EW-1:0] kx;
        logic [EW-1:0] mask;
        logic [EW-1:0] e;
        kx   = EW'(k);
        mask = (EW'(1) << s) - EW'(1);
        e    = (kx & mask) << (3'(KW) - s);
        if (inv) begin
            e = EW'(0) - e;
        end
        return e;
    endfunction

    // Returns {bypass, typesel}; typesel = {swap re/im, negate re, negate im}
    function automatic logic [3:0] f_class(input logic [EW-1:0] e);
        logic [3:0] cls;
        cls = 4'b0_000;
        if (e == '0) begin
            cls = 4'b1_000;
        end else if (e == E_Q1) begin
            cls = 4'b1_101;
        end else if (e == E_Q2) begin
            cls = 4'b1_011;
        end else if (e == E_Q3) begin
            cls = 4'b1_110;
        end
        return cls;
    endfunction

`ifdef TWSEQ_INVERSE_EN
    assign w_inv_in = i_inv;
`else
    assign w_inv_in = 1'b0;
`endif

    assign w_stage_cl  = (i_stage > 3'(MAX_STAGE)) ? 3'(MAX_STAGE) : i_stage;
    assign w_k_next    = r_k + KW'(1);
    assign w_exp_next  = f_exp(w_k_next, r_stage, r_inv);
    assign w_cls_next  = f_class(w_exp_next);
    assign w_exp_first = f_exp('0, w_stage_cl, w_inv_in);
    assign w_cls_first = f_class(w_exp_first);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_stage   <= '0;
            r_inv     <= 1'b0;
            r_k       <= '0;
            r_tw_exp  <= '0;
            r_bypass  <= 1'b0;
            r_typesel <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_stage   <= w_stage_cl;
                        r_inv     <= w_inv_in;
                        r_k       <= '0;
                        r_tw_exp  <= w_exp_first;
                        r_bypass  <= w_cls_first[3];
                        r_typesel <= w_cls_first[2:0];
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= StRun;
                    end
                end
                StRun: begin
                    if (r_valid && i_ready) begin
                        if (r_k == LAST_K) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StFin;
                        end else begin
                            r_k       <= w_k_next;
                            r_tw_exp  <= w_exp_next;
                            r_bypass  <= w_cls_next[3];
                            r_typesel <= w_cls_next[2:0];
                        end
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_k       = r_k;
    assign o_tw_exp  = r_tw_exp;
    assign o_bypass  = r_bypass;
    assign o_typesel = r_typesel;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_twiddle_type_seq.sv
// Bench for twiddle_type_seq: vector table, directed stall/abort sequences and random runs
// checked against an arithmetic reference model. Inverse cases need TWSEQ_INVERSE_EN.
module tb_twiddle_type_seq;

`ifdef TWSEQ_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] stage;
    logic       ready;
    logic       inv;
    logic [4:0] k;
    logic [5:0] tw_exp;
    logic       bypass;
    logic [2:0] typesel;
    logic       valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    twiddle_type_seq #(.LOG2N(6)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stage   (stage),
        .i_ready   (ready),
`ifdef TWSEQ_INVERSE_EN
        .i_inv     (inv),
`endif
        .o_k       (k),
        .o_tw_exp  (tw_exp),
        .o_bypass  (bypass),
        .o_typesel (typesel),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_done    (done)
    );

    typedef struct {
        int         stage;
        bit         inv;
        int         k;
        int         e;
        bit         byp;
        logic [2:0] ts;
    } vec_t;

    vec_t tbl[$];

    // Reference: {e[5:0], bypass, typesel} from the twiddle definition
    function automatic logic [9:0] model(input int st, input bit iv, input int kk);
        int         s;
        int         e;
        bit         byp;
        logic [2:0] ts;
        s = (st > 5) ? 5 : st;
        e = (kk % (2 ** s)) * (2 ** (5 - s));
        if (iv) e = (64 - e) % 64;
        byp = (e % 16) == 0;
        ts  = 3'b000;
        if (byp) begin
            case (e / 16)
                1: ts = 3'b101;
                2: ts = 3'b011;
                3: ts = 3'b110;
                default: ts = 3'b000;
            endcase
        end
        return {e[5:0], byp, ts};
    endfunction

    function automatic logic [17:0] act_vec();
        return {valid, busy, done, k, tw_exp, bypass, typesel};
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (v,b,d,k,e,byp,ts)", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input bit ev, input bit eb, input bit ed);
        chk(name, {15'd0, valid, busy, done}, {15'd0, ev, eb, ed});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int st, input bit iv);
        stage = 3'(st);
        inv   = iv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: alternate, with 4-cycle hold at K=7
    task automatic run_stage(input int st, input bit iv, input int mode, input int exp_byp,
                             input string tag);
        int         exp_k;
        int         cyc;
        int         hold;
        int         nbyp;
        bit         rdy;
        logic [9:0] f;
        exp_k = 0;
        cyc   = 0;
        hold  = 0;
        nbyp  = 0;
        do_start(st, iv);
        while (exp_k < 32 && cyc < 400) begin
            stage = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 7) == 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    rdy = (cyc % 2) == 1;
                    if (exp_k == 7 && hold < 4) begin
                        rdy = 1'b0;
                        hold++;
                    end
                end
            endcase
            ready = rdy;
            f = model(st, iv, exp_k);
            chk({tag, "_item"}, act_vec(), {3'b110, 5'(exp_k), f});
            step();
            cyc++;
            if (rdy) begin
                nbyp += int'(f[3]);
                exp_k++;
            end
        end
        if (cyc >= 400) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got %0d items expected 32", tag, exp_k);
        end
        // FIN cycle: DONE pulse, and a START here must be ignored
        start = 1'b1;
        stage = 3'd0;
        ready = 1'b1;
        chk_ctl({tag, "_fin"}, 1'b0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        chk_ctl({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctl({tag, "_idle2"}, 1'b0, 1'b0, 1'b0);
        if (exp_byp >= 0) begin
            chk({tag, "_nbyp"}, 18'(nbyp), 18'(exp_byp));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        rst   = 1'b1;
        start = 1'b0;
        stage = 3'd0;
        ready = 1'b0;
        inv   = 1'b0;
        step();
        step();
        chk("reset", act_vec(), 18'd0);
        rst = 1'b0;
        step();
        chk("reset_idle", act_vec(), 18'd0);

        tbl.push_back('{0, 1'b0, 0, 0, 1'b1, 3'b000});
        tbl.push_back('{0, 1'b0, 31, 0, 1'b1, 3'b000});
        tbl.push_back('{1, 1'b0, 1, 16, 1'b1, 3'b101});
        tbl.push_back('{1, 1'b0, 2, 0, 1'b1, 3'b000});
        tbl.push_back('{1, 1'b0, 31, 16, 1'b1, 3'b101});
        tbl.push_back('{2, 1'b0, 1, 8, 1'b0, 3'b000});
        tbl.push_back('{2, 1'b0, 2, 16, 1'b1, 3'b101});
        tbl.push_back('{2, 1'b0, 3, 24, 1'b0, 3'b000});
        tbl.push_back('{3, 1'b0, 7, 28, 1'b0, 3'b000});
        tbl.push_back('{4, 1'b0, 8, 16, 1'b1, 3'b101});
        tbl.push_back('{4, 1'b0, 4, 8, 1'b0, 3'b000});
        tbl.push_back('{5, 1'b0, 5, 5, 1'b0, 3'b000});
        tbl.push_back('{5, 1'b0, 16, 16, 1'b1, 3'b101});
        tbl.push_back('{7, 1'b0, 1, 1, 1'b0, 3'b000});
        tbl.push_back('{6, 1'b0, 31, 31, 1'b0, 3'b000});
`ifdef TWSEQ_INVERSE_EN
        tbl.push_back('{1, 1'b1, 1, 48, 1'b1, 3'b110});
        tbl.push_back('{1, 1'b1, 0, 0, 1'b1, 3'b000});
        tbl.push_back('{5, 1'b1, 1, 63, 1'b0, 3'b000});
        tbl.push_back('{2, 1'b1, 2, 48, 1'b1, 3'b110});
        tbl.push_back('{5, 1'b1, 16, 48, 1'b1, 3'b110});
        tbl.push_back('{5, 1'b0, 1, 1, 1'b0, 3'b000});
`endif

        // Advance to the listed K with READY high, check while stalled, then abort with reset
        foreach (tbl[i]) begin
            do_start(tbl[i].stage, tbl[i].inv);
            ready = 1'b1;
            repeat (tbl[i].k) step();
            ready = 1'b0;
            step();
            chk($sformatf("tbl%0d", i), act_vec(),
                {3'b110, 5'(tbl[i].k), 6'(tbl[i].e), tbl[i].byp, tbl[i].ts});
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk_ctl($sformatf("tbl%0d_abort", i), 1'b0, 1'b0, 1'b0);
        end

        run_stage(0, 1'b0, 0, 32, "st0");
        run_stage(1, 1'b0, 0, 32, "st1");
        run_stage(5, 1'b0, 0, 2, "st5");
        run_stage(3, 1'b0, 2, 8, "st3_stall");
        run_stage(7, 1'b0, 1, 2, "st7_clamp");
`ifdef TWSEQ_INVERSE_EN
        run_stage(1, 1'b1, 0, 32, "st1_inv");
        run_stage(5, 1'b1, 1, 2, "st5_inv");
`endif

        // Reset mid-run at K=10 of stage 2: no DONE for the aborted stage
        do_start(2, 1'b0);
        ready = 1'b1;
        repeat (10) step();
        ready = 1'b0;
        f = model(2, 1'b0, 10);
        chk("abort_k10", act_vec(), {3'b110, 5'd10, f});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rst", act_vec(), 18'd0);
        ready = 1'b1;
        repeat (3) begin
            step();
            chk_ctl("abort_nodone", 1'b0, 1'b0, 1'b0);
        end

        // Reset and START together: reset wins
        start = 1'b1;
        stage = 3'd5;
        rst   = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start", act_vec(), 18'd0);
        step();
        chk_ctl("rst_start_idle", 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int st;
            bit iv;
            st = $urandom_range(0, 7);
            iv = INV_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            run_stage(st, iv, 1, -1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
